po2_quantise: RTL and testbench
===============================

Name: po2_quantise

Overview:
- Encoder counterpart of the power-of-two multiplier: converts a signed fixed-point weight into the (zero_weight, negative_weight, log_2_weight) triple that the multiplier consumes, with |w| ≈ 2^-log_2_weight.
- Sits between the weight memory/loader and the net's multiply units.
- Ready/valid on both sides.
- Iterative leading-one scan, one bit per cycle, then round-to-nearest power of two.

Parameters:
W, 16, width of weight and of log_2_weight
I, 4, integer bits in W; fractional bits F = W-I
MAX_SHIFT, 10, largest log_2_weight emitted; anything smaller in magnitude becomes zero_weight

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
in_valid  input  1  weight valid
in_ready  output  1  block idle, can accept
weight  input  W  signed fixed-point weight, Q(I).(F)
out_valid  output  1  encoded result valid
out_ready  input  1  consumer accepts result
zero_weight  output  1  quantised weight is zero
negative_weight  output  1  weight was negative
log_2_weight  output  W  right-shift amount k, 0..MAX_SHIFT

Behaviour:
- Reset (rst high at a clk edge):
  - state IDLE; out_valid=0, zero_weight=0, negative_weight=0, log_2_weight=0.
  - Any in-flight conversion is abandoned; rst mid-operation gives no output.
- in_ready = (state==IDLE), combinational; it is 1 in the first cycle after reset deasserts.
- IDLE:
  - On in_valid & in_ready at edge e0: latch weight; set negative_weight = weight[W-1]; go to ABS.
- ABS (one edge):
  - mag = |weight| as unsigned W bits.
  - weight == -2^(W-1) saturates to mag = 2^(W-1)-1.
  - If weight==0: zero_weight=1, negative_weight=0, log_2_weight=0, out_valid=1, go to DONE. Zero-weight out_valid is high after edge e0+1.
  - Otherwise pos=W-1; go to SCAN.
- SCAN:
  - If mag[W-1]==0: mag<<=1, pos-=1, stay in SCAN.
  - If mag[W-1]==1: go to ROUND. At this point p = pos is the leading-one bit index of the original magnitude.
- ROUND (one edge; sets out_valid=1, goes to DONE):
  - If p >= F (|w| >= 1.0): k = 0.
  - Else k = F-p; if p>0 and original bit p-1 is set, round up: k = k-1. Bit p-1 is mag[W-2] after normalisation.
  - If k > MAX_SHIFT: zero_weight=1, log_2_weight=0; negative_weight keeps the sign.
  - Else zero_weight=0, log_2_weight=k.
- Non-zero latency: out_valid high after edge e0 + (W-p+2).
- DONE:
  - Outputs held stable while out_valid & !out_ready.
  - On out_valid & out_ready: out_valid=0, go to IDLE; in_ready is high the next cycle.
  - Minimum 1 idle cycle between conversions; no accept in the same cycle as output handshake.
- Outputs change only on entry to DONE; no glitch values while in_ready=0.

Optional Feature:
- Macro PO2_QUANTISE_ERR_EN.
- When defined: extra output quant_err, signed W bits, registered, valid with out_valid.
  - Value is weight minus the quantised value in the same Q(I).(F) format.
  - The quantised value is ±2^(F-k) LSBs, or 0 when zero_weight.
  - Uses the original (unsaturated) weight.
- When undefined: port and its logic absent; all other behaviour identical.

Test Plan:
- W=16,I=4,MAX_SHIFT=10; weight 0x0800 (0.5) -> zero=0, neg=0, k=1, out_valid exactly 7 edges after accept; with ERR_EN quant_err=0x0000.
- weight 0x0C00 (0.75) -> round up, k=0; weight 0x04CD (≈0.3) -> k=2, neg=0; with ERR_EN quant_err=0x00CD for 0x04CD.
- weight 0xF800 (-0.5) -> neg=1, k=1; weight 0x8000 (-8.0) -> saturate, neg=1, k=0, zero=0; with ERR_EN quant_err=0x9000.
- weight 0x0000 -> zero=1, neg=0, k=0, out_valid 1 edge after accept; weight 0x0001 (k=12>10) -> zero=1, neg=0; weight 0xFFFF -> zero=1, neg=1.
- Backpressure: hold out_ready=0 for 20 cycles -> outputs stable, in_ready=0, new in_valid ignored; release -> one handshake, in_ready=1 next cycle.
- Pulse rst for one cycle mid-SCAN -> next cycle out_valid=0, in_ready=1, flags 0; the following conversion of 0x0800 is correct.

Source files
------------

// File: rtl/po2_quantise.sv
// Signed Q(I).(F) weight -> (zero, negative, log2) power-of-two encoder using an iterative leading-one scan.
// Optional quantisation-error output enabled by defining PO2_QUANTISE_ERR_EN.
module po2_quantise #(
  parameter int W         = 16,
  parameter int I         = 4,
  parameter int MAX_SHIFT = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] weight,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         zero_weight,
  output logic         negative_weight,
`ifdef PO2_QUANTISE_ERR_EN
  output logic [W-1:0] quant_err,
`endif
  output logic [W-1:0] log_2_weight
);

  localparam int F  = W - I;
  localparam int PW = $clog2(W) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ABS, S_SCAN, S_ROUND, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic signed [W-1:0]   r_weight;
  logic        [W-1:0]   r_mag;
  logic        [PW-1:0]  r_pos;
  logic                  r_sign;
  logic                  r_out_valid;
  logic                  r_zero;
  logic                  r_neg;
  logic        [W-1:0]   r_k;
  logic        [PW-1:0]  w_k;
  logic                  w_k_zero;
  logic                  w_in_zero;

  // Magnitude with the most negative code clamped so it stays representable.
  function automatic logic [W-1:0] sat_abs(input logic signed [W-1:0] v);
    logic [W-1:0] u;
    u = $unsigned(v);
    if (u == {1'b1, {(W-1){1'b0}}})
      return {1'b0, {(W-1){1'b1}}};
    else if (u[W-1])
      return ~u + {{(W-1){1'b0}}, 1'b1};
    else
      return u;
  endfunction

  // Round-to-nearest shift amount from leading-one index p and the bit just below it.
  function automatic logic [PW-1:0] round_k(input logic [PW-1:0] p, input logic below);
    logic [PW-1:0] k;
    if (p >= PW'(F)) begin
      k = '0;
    end else begin
      k = PW'(F) - p;
      if ((p != '0) && below)
        k = k - PW'(1);
    end
    return k;
  endfunction

`ifdef PO2_QUANTISE_ERR_EN
  logic [W-1:0] r_err;

  // Error against the unsaturated weight; the quantised value is +/-2^(F-k) LSBs or zero.
  function automatic logic signed [W-1:0] quant_error(input logic signed [W-1:0] w,
                                                      input logic [PW-1:0] k,
                                                      input logic zero);
    logic signed [W:0] wx;
    logic signed [W:0] q;
    logic signed [W:0] d;
    wx = $signed({w[W-1], w});
    q  = '0;
    if (!zero) begin
      q = $signed((W+1)'(1) << (PW'(F) - k));
      if (w[W-1])
        q = -q;
    end
    d = wx - q;
    return $signed(d[W-1:0]);
  endfunction

  assign quant_err = r_err;
`endif

  assign in_ready        = (r_state == S_IDLE);
  assign out_valid       = r_out_valid;
  assign zero_weight     = r_zero;
  assign negative_weight = r_neg;
  assign log_2_weight    = r_k;

  assign w_in_zero = (r_weight == '0);
  assign w_k       = round_k(r_pos, r_mag[W-2]);
  assign w_k_zero  = (w_k > PW'(MAX_SHIFT));

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ABS;
      S_ABS:   w_next = w_in_zero ? S_DONE : S_SCAN;
      S_SCAN:  if (r_mag[W-1]) w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Working registers: latch, normalise, shift until the leading one reaches the MSB.
  always_ff @(posedge clk) begin
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          r_weight <= $signed(weight);
          r_sign   <= weight[W-1];
        end
      end
      S_ABS: begin
        r_mag <= sat_abs(r_weight);
        r_pos <= PW'(W-1);
      end
      S_SCAN: begin
        if (!r_mag[W-1]) begin
          r_mag <= r_mag << 1;
          r_pos <= r_pos - PW'(1);
        end
      end
      default: ;
    endcase
  end

  // Visible outputs only update on entry to DONE so they never glitch mid-conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_k         <= '0;
`ifdef PO2_QUANTISE_ERR_EN
      r_err       <= '0;
`endif
    end else begin
      unique case (r_state)
        S_ABS: begin
          if (w_in_zero) begin
            r_out_valid <= 1'b1;
            r_zero      <= 1'b1;
            r_neg       <= 1'b0;
            r_k         <= '0;
`ifdef PO2_QUANTISE_ERR_EN
            r_err       <= '0;
`endif
          end
        end
        S_ROUND: begin
          r_out_valid <= 1'b1;
          r_neg       <= r_sign;
          r_zero      <= w_k_zero;
          r_k         <= w_k_zero ? '0 : W'(w_k);
`ifdef PO2_QUANTISE_ERR_EN
          r_err       <= quant_error(r_weight, w_k, w_k_zero);
`endif
        end
        S_DONE: begin
          if (out_ready)
            r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_po2_quantise.sv
// Directed and randomised bench for po2_quantise against an arithmetic reference model.
module tb_po2_quantise;

  localparam int W         = 16;
  localparam int I         = 4;
  localparam int F         = W - I;
  localparam int MAX_SHIFT = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  weight;
  logic          out_valid;
  logic          out_ready;
  logic          zero_weight;
  logic          negative_weight;
  logic [W-1:0]  log_2_weight;
`ifdef PO2_QUANTISE_ERR_EN
  logic [W-1:0]  quant_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  po2_quantise #(.W(W), .I(I), .MAX_SHIFT(MAX_SHIFT)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .weight          (weight),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .zero_weight     (zero_weight),
    .negative_weight (negative_weight),
`ifdef PO2_QUANTISE_ERR_EN
    .quant_err       (quant_err),
`endif
    .log_2_weight    (log_2_weight)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: nearest power of two of |w| by plain integer arithmetic.
  task automatic model(input logic [W-1:0] w, output logic ez, output logic en,
                       output int ek, output int elat, output logic [W-1:0] eerr);
    int wi, mag, p, q, e;
    wi  = int'($signed(w));
    mag = (wi < 0) ? -wi : wi;
    if (mag > (1 << (W-1)) - 1) mag = (1 << (W-1)) - 1;
    if (mag == 0) begin
      ez = 1'b1; en = 1'b0; ek = 0; elat = 1; eerr = '0;
      return;
    end
    p = 0;
    while ((1 << (p + 1)) <= mag) p++;
    if (p >= F) ek = 0;
    else ek = F - p - (((2 * mag) >= (3 * (1 << p))) ? 1 : 0);
    en   = (wi < 0);
    ez   = (ek > MAX_SHIFT);
    elat = W - p + 2;
    if (ez) ek = 0;
    q = ez ? 0 : (1 << (F - ek));
    if (en) q = -q;
    e    = wi - q;
    eerr = e[W-1:0];
  endtask

  // One full conversion with out_ready high; called #1 after a clock edge.
  task automatic conv(input string tag, input logic [W-1:0] w, input logic ez, input logic en,
                      input int ek, input int elat, input logic [W-1:0] eerr);
    int  n;
    bit  got;
    chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    weight   = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    weight   = W'($urandom);
    chk({tag, ".busy"}, 32'(in_ready), 32'd0);
    got = 1'b0;
    n   = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1'b1;
        n   = c;
        break;
      end
    end
    if (!got) begin
      chk({tag, ".timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, ".latency"}, 32'(n), 32'(elat));
    chk({tag, ".zero"}, 32'(zero_weight), 32'(ez));
    chk({tag, ".neg"}, 32'(negative_weight), 32'(en));
    chk({tag, ".k"}, 32'(log_2_weight), 32'(ek));
`ifdef PO2_QUANTISE_ERR_EN
    chk({tag, ".err"}, 32'(quant_err), 32'(eerr));
`else
    if (eerr === 'x) chk({tag, ".err_x"}, 32'd0, 32'd1);
`endif
    @(posedge clk); #1;
    chk({tag, ".ov_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_post"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic          ez, en;
    int            ek, elat;
    logic [W-1:0]  eerr;
    logic [W-1:0]  hz_k;
    logic          hz_z, hz_n;
    logic signed [W-1:0] s;
    bit            got;

    rst = 1'b1; in_valid = 1'b0; weight = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.zero", 32'(zero_weight), 32'd0);
    chk("rst.neg", 32'(negative_weight), 32'd0);
    chk("rst.k", 32'(log_2_weight), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    conv("half",    16'h0800, 1'b0, 1'b0, 1, 7,  16'h0000);
    conv("p75",     16'h0C00, 1'b0, 1'b0, 0, 7,  16'hFC00);
    conv("p30",     16'h04CD, 1'b0, 1'b0, 2, 8,  16'h00CD);
    conv("mhalf",   16'hF800, 1'b0, 1'b1, 1, 7,  16'h0000);
    conv("mmin",    16'h8000, 1'b0, 1'b1, 0, 4,  16'h9000);
    conv("zero",    16'h0000, 1'b1, 1'b0, 0, 1,  16'h0000);
    conv("lsb",     16'h0001, 1'b1, 1'b0, 0, 18, 16'h0001);
    conv("mlsb",    16'hFFFF, 1'b1, 1'b1, 0, 18, 16'hFFFF);

    // Backpressure: result must hold and new requests must be ignored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    weight    = 16'h0C00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin got = 1'b1; break; end
    end
    chk("bp.valid_seen", 32'(got), 32'd1);
    hz_k = log_2_weight; hz_z = zero_weight; hz_n = negative_weight;
    chk("bp.k", 32'(hz_k), 32'd0);
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      weight   = 16'h0800;
      @(posedge clk); #1;
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_k", 32'(log_2_weight), 32'(hz_k));
      chk("bp.hold_flags", {30'd0, zero_weight, negative_weight}, {30'd0, hz_z, hz_n});
      chk("bp.in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp.no_accept", 32'(in_ready), 32'd1);

    // Reset mid-scan abandons the conversion; leave flags set beforehand.
    conv("pre_rst", 16'hFFFF, 1'b1, 1'b1, 0, 18, 16'hFFFF);
    in_valid = 1'b1;
    weight   = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst.flags", {30'd0, zero_weight, negative_weight}, 32'd0);
    repeat (20) @(posedge clk);
    #1 chk("mid_rst.no_output", 32'(out_valid), 32'd0);
    conv("after_rst", 16'h0800, 1'b0, 1'b0, 1, 7, 16'h0000);

    // Randomised weights spread across magnitudes.
    for (int t = 0; t < 60; t++) begin
      s = $signed(W'($urandom));
      s = s >>> $urandom_range(0, W-1);
      model(s, ez, en, ek, elat, eerr);
      conv("rand", s, ez, en, ek, elat, eerr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
